// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Holds the per-channel mode encodings, default parameter values and the
// helper that decides whether an accepted edge matches a channel's mode.
package edge_det_pkg;

  // Per-channel mode encodings. Bit 0 enables rise events, bit 1 enables fall events.
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Default parameter values
  localparam int unsigned DEF_N_CH        = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_W      = 4;

  // True when an accepted edge is one the channel's mode asks to report
  function automatic logic ev_match(input logic [1:0] mode,
                                    input logic       pe,
                                    input logic       ne);
    return (pe & mode[0]) | (ne & mode[1]);
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel of the edge detector: input synchroniser, glitch filter with
// stability counter, filtered level, rise/fall/event pulses and sticky flag.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_sig            raw asynchronous input
//   i_mode[1:0]      00 off, 01 rise, 10 fall, 11 both
//   i_filt_len       filter length L (edge accepted after L+1 mismatching samples)
//   i_clr            write-1-to-clear strobe for the flag
//   o_level          filtered, synchronised level
//   o_pe, o_ne       one-cycle pulses on accepted rising / falling edges
//   o_ev             one-cycle pulse on an accepted edge matching i_mode
//   o_flag           sticky event flag
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_W      = DEF_FILT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sig,
  input  logic [1:0]        i_mode,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic              i_clr,
  output logic              o_level,
  output logic              o_pe,
  output logic              o_ne,
  output logic              o_ev,
  output logic              o_flag
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pe_q, pe_d;
  logic                   ne_q, ne_d;
  logic                   ev_q, ev_d;
  logic                   flag_q, flag_d;
  logic                   s;
  logic                   accept;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state: synchroniser shift, filter count, pulse generation, flag update
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_sig};
    level_d = level_q;
    cnt_d   = '0;
    accept  = 1'b0;

    // >= lets a shortened filter length take effect mid-count; cnt stays below L,
    // so the increment never wraps.
    if (s != level_q) begin
      if (cnt_q >= i_filt_len) begin
        level_d = s;
        accept  = 1'b1;
      end else begin
        cnt_d = cnt_q + FILT_W'(1);
      end
    end

    pe_d   = accept & s;
    ne_d   = accept & ~s;
    ev_d   = ev_match(i_mode, pe_d, ne_d);
    // A set in the same cycle as a clear wins
    flag_d = (flag_q & ~i_clr) | ev_d;
  end

  // State registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pe_q    <= 1'b0;
      ne_q    <= 1'b0;
      ev_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pe_q    <= pe_d;
      ne_q    <= ne_d;
      ev_q    <= ev_d;
      flag_q  <= flag_d;
    end
  end

  assign o_level = level_q;
  assign o_pe    = pe_q;
  assign o_ne    = ne_q;
  assign o_ev    = ev_q;
  assign o_flag  = flag_q;

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: N_CH independent synchronised, glitch-filtered
// edge detectors with per-channel mode and sticky flags, plus a summary flag.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_sig[N_CH]      raw asynchronous inputs
//   i_mode[2*N_CH]   per-channel mode, bits [2i+1:2i]
//   i_filt_len       shared filter length L
//   i_clr[N_CH]      write-1-to-clear flag strobes
//   o_level, o_pe, o_ne, o_ev, o_flag   per-channel registered outputs
//   o_any            OR of all flags, combinational from the flag registers
module edge_detector_multi
  import edge_det_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_W      = DEF_FILT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_CH-1:0]   i_sig,
  input  logic [2*N_CH-1:0] i_mode,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic [N_CH-1:0]   i_clr,
  output logic [N_CH-1:0]   o_level,
  output logic [N_CH-1:0]   o_pe,
  output logic [N_CH-1:0]   o_ne,
  output logic [N_CH-1:0]   o_ev,
  output logic [N_CH-1:0]   o_flag,
  output logic              o_any
);

  logic [N_CH-1:0] flag;

  // One detector per channel
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_sig      (i_sig[g]),
      .i_mode     (i_mode[2*g +: 2]),
      .i_filt_len (i_filt_len),
      .i_clr      (i_clr[g]),
      .o_level    (o_level[g]),
      .o_pe       (o_pe[g]),
      .o_ne       (o_ne[g]),
      .o_ev       (o_ev[g]),
      .o_flag     (flag[g])
    );
  end

  assign o_flag = flag;
  assign o_any  = |flag;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: directed scenarios followed by randomized
// stimulus, all outputs compared each cycle against a behavioural model.
module tb_edge_detector_multi;

  localparam int unsigned N_CH        = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILT_W      = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   sig;
  logic [2*N_CH-1:0] mode;
  logic [FILT_W-1:0] filt_len;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   level, pe, ne, ev, flag;
  logic              any;

  int checks = 0;
  int errors = 0;

  // Model: input history as seen through the synchroniser, then run-length filter
  logic [N_CH-1:0] m_hist[$];
  logic [N_CH-1:0] m_level, m_pe, m_ne, m_ev, m_flag;
  int              m_run[N_CH];

  edge_detector_multi #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sig(sig), .i_mode(mode),
    .i_filt_len(filt_len), .i_clr(clr),
    .o_level(level), .o_pe(pe), .o_ne(ne), .o_ev(ev),
    .o_flag(flag), .o_any(any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_hist.push_back('0);
    m_level = '0; m_pe = '0; m_ne = '0; m_ev = '0; m_flag = '0;
    for (int c = 0; c < int'(N_CH); c++) m_run[c] = 0;
  endtask

  // An edge is accepted once the synchronised input has differed from the
  // level for L+1 consecutive samples.
  task automatic model_step();
    logic [N_CH-1:0] s;
    s = m_hist.pop_front();
    m_hist.push_back(sig);
    m_pe = '0; m_ne = '0; m_ev = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (s[c] !== m_level[c]) begin
        m_run[c]++;
        if (m_run[c] >= int'(filt_len) + 1) begin
          m_level[c] = s[c];
          m_run[c]   = 0;
          if (s[c]) m_pe[c] = 1'b1;
          else      m_ne[c] = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
      m_ev[c] = (m_pe[c] & mode[2*c]) | (m_ne[c] & mode[2*c+1]);
    end
    m_flag = (m_flag & ~clr) | m_ev;
  endtask

  task automatic chk_all();
    chk("level", 32'(level), 32'(m_level));
    chk("pe",    32'(pe),    32'(m_pe));
    chk("ne",    32'(ne),    32'(m_ne));
    chk("ev",    32'(ev),    32'(m_ev));
    chk("flag",  32'(flag),  32'(m_flag));
    chk("any",   32'(any),   32'(|m_flag));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_pe"},    32'(pe),    32'd0);
    chk({tag, "_ne"},    32'(ne),    32'd0);
    chk({tag, "_ev"},    32'(ev),    32'd0);
    chk({tag, "_flag"},  32'(flag),  32'd0);
    chk({tag, "_any"},   32'(any),   32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  initial begin
    rst      = 1'b1;
    sig      = '0;
    clr      = '0;
    filt_len = '0;
    // ch0 rise, ch1 both, ch2 fall, ch3 off, ch4 rise, ch5..7 both
    mode     = {2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    model_reset();

    // Reset state, including across a clock edge
    #2;
    chk_zero("rst_async");
    @(posedge clk); #1;
    chk_zero("rst_edge");
    rst = 1'b0;
    repeat (2) tick();

    // ch0 rise, L=0: pulse at edge k+2, flag and any follow
    sig[0] = 1'b1;
    tick(); chk("A_pe0_k0", 32'(pe[0]), 32'd0);
    tick(); chk("A_pe0_k1", 32'(pe[0]), 32'd0);
    tick();
    chk("A_pe0_k2",    32'(pe[0]),    32'd1);
    chk("A_level0_k2", 32'(level[0]), 32'd1);
    chk("A_ev0_k2",    32'(ev[0]),    32'd1);
    tick();
    chk("A_pe0_k3",   32'(pe[0]),   32'd0);
    chk("A_ev0_k3",   32'(ev[0]),   32'd0);
    chk("A_flag0_k3", 32'(flag[0]), 32'd1);
    chk("A_any_k3",   32'(any),     32'd1);

    // ch1 both, L=3: 3-cycle glitch rejected, held edges accepted at k+5
    filt_len = FILT_W'(3);
    sig[1] = 1'b1;
    repeat (3) tick();
    sig[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("B_glitch_level1", 32'(level[1]), 32'd0);
      chk("B_glitch_pe1",    32'(pe[1]),    32'd0);
    end
    sig[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("B_rise_early_pe1", 32'(pe[1]), 32'd0);
    end
    tick();
    chk("B_pe1_k5",    32'(pe[1]),    32'd1);
    chk("B_ev1_k5",    32'(ev[1]),    32'd1);
    chk("B_level1_k5", 32'(level[1]), 32'd1);
    sig[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("B_fall_early_ne1", 32'(ne[1]), 32'd0);
    end
    tick();
    chk("B_ne1_k5", 32'(ne[1]), 32'd1);
    chk("B_ev1_fall", 32'(ev[1]), 32'd1);

    // ch2 fall mode, L=0: rise gives pe only, fall gives ne+ev+flag
    filt_len = '0;
    sig[2] = 1'b1;
    repeat (2) tick();
    tick();
    chk("C_pe2",   32'(pe[2]),   32'd1);
    chk("C_ev2_r", 32'(ev[2]),   32'd0);
    chk("C_flag2", 32'(flag[2]), 32'd0);
    sig[2] = 1'b0;
    repeat (2) tick();
    tick();
    chk("C_ne2",     32'(ne[2]),   32'd1);
    chk("C_ev2_f",   32'(ev[2]),   32'd1);
    chk("C_flag2_f", 32'(flag[2]), 32'd1);

    // ch3 off: toggling every cycle gives alternating pulses, never ev/flag
    for (int i = 0; i < 8; i++) begin
      sig[3] = ~sig[3];
      tick();
      chk("D_ev3",   32'(ev[3]),   32'd0);
      chk("D_flag3", 32'(flag[3]), 32'd0);
      if (i >= 3) chk("D_pe_ne3_one", 32'(pe[3] ^ ne[3]), 32'd1);
    end
    repeat (3) tick();

    // Flag priority: set wins over simultaneous clear, lone clear drops the flag
    clr = '1;
    tick();
    clr = '0;
    chk("E_all_clear_any", 32'(any), 32'd0);
    sig[0] = 1'b0;
    repeat (3) tick();
    sig[0] = 1'b1;
    repeat (2) tick();
    clr[0] = 1'b1;
    tick();
    chk("E_ev0_with_clr",   32'(ev[0]),   32'd1);
    chk("E_flag0_set_wins", 32'(flag[0]), 32'd1);
    tick();
    chk("E_flag0_cleared", 32'(flag[0]), 32'd0);
    chk("E_any_cleared",   32'(any),     32'd0);
    clr = '0;

    // Reset mid-count on ch4 with L=7, then rising edge after SYNC_STAGES+8 cycles
    filt_len = FILT_W'(7);
    sig[4] = 1'b1;
    repeat (5) tick();
    chk("F_pe4_counting", 32'(pe[4]), 32'd0);
    rst = 1'b1;
    #1;
    chk_zero("F_rst_mid");
    model_reset();
    #2;
    rst = 1'b0;
    for (int i = 0; i < int'(SYNC_STAGES) + 7; i++) begin
      tick(); chk("F_pe4_early", 32'(pe[4]), 32'd0);
    end
    tick();
    chk("F_pe4_post_rst",    32'(pe[4]),    32'd1);
    chk("F_level4_post_rst", 32'(level[4]), 32'd1);

    // Randomized traffic with mode, filter length and clear changes
    for (int i = 0; i < 400; i++) begin
      if (i % 20 == 0) filt_len = FILT_W'($urandom_range(0, 3));
      if (i % 50 == 0) mode = (2*N_CH)'($urandom);
      sig = sig ^ (N_CH'($urandom) & N_CH'($urandom));
      clr = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
Parametrised multi-channel edge detector. Successor to the single-channel posedge detector. Each channel has:
- an input synchroniser
- a programmable glitch filter
- rise/fall/both detection selected per channel
- a sticky event flag with write-1-to-clear.

It sits between raw asynchronous status/button/interrupt inputs and the control logic. A summary flag feeds the interrupt line.

Parameters:
N_CH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_W, 4, width of the filter length field and per-channel stability counter

Ports:
i_clk  in  1  system clock; all logic on its rising edge
i_rst  in  1  asynchronous, active-high reset
i_sig  in  N_CH  raw, possibly asynchronous inputs; bit i = channel i
i_mode  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
i_filt_len  in  FILT_W  filter length L, shared by all channels; 0 = no filtering
i_clr  in  N_CH  write-1-to-clear for o_flag, one-cycle strobe per bit
o_level  out  N_CH  filtered, synchronised level per channel (registered)
o_pe  out  N_CH  one-cycle pulse on an accepted rising edge, regardless of mode
o_ne  out  N_CH  one-cycle pulse on an accepted falling edge, regardless of mode
o_ev  out  N_CH  one-cycle pulse on an accepted edge that matches i_mode
o_flag  out  N_CH  sticky event flag per channel
o_any  out  1  OR-reduction of o_flag (combinational from flag registers)

Behaviour:
- Reset, asynchronous, active-high. While i_rst=1, all of the following are 0:
  - synchroniser flops, filtered levels, stability counters
  - o_level, o_pe, o_ne, o_ev, o_flag, o_any
- Reset mid-operation aborts any in-progress filter count immediately.
- Synchroniser: i_sig[i] passes through SYNC_STAGES flops; s[i] is the last stage. No other logic reads i_sig.
- Filter, per channel, evaluated each rising i_clk:
  - s==level: cnt<=0.
  - s!=level and cnt>=L: level<=s, cnt<=0, edge accepted.
  - s!=level otherwise: cnt<=cnt+1.
  - Using >= makes a reduction of L during a count take effect at once. cnt never exceeds 2^FILT_W-1.
- An edge is accepted only after s differs from level for L+1 consecutive samples. Shorter glitches are rejected, with no outputs.
- Latency: i_sig stable from before edge k → o_level and o_pe/o_ne update at edge k+SYNC_STAGES+L. Default, L=0: edge k+2.
- Pulses:
  - o_pe = accepted edge with new level 1.
  - o_ne = accepted edge with new level 0.
  - Each is registered, high exactly one cycle, coincident with the o_level change.
  - o_pe and o_ne are never high together on one channel.
  - Back-to-back edges are possible when L=0: the input toggles every cycle, so pulses alternate.
- o_ev: o_pe & mode[0] | o_ne & mode[1]. Same cycle as o_pe/o_ne. Mode 00 suppresses o_ev and flag setting, but o_pe/o_ne/o_level still operate.
- i_mode/i_filt_len changes apply from the next clock edge; no history is re-evaluated.
- Flags: flag <= (flag & ~i_clr) | ev. A flag rises on the same edge that o_ev goes high. A set in the same cycle as a clear wins (the flag stays 1). Clearing a 0 flag is harmless.
- o_any: 1 whenever any o_flag bit is 1. No extra latency.
- Post-reset: if i_sig is already 1 when reset deasserts, a rising edge is reported after the normal latency. This is intended; software clears the flag after init.

Decomposition:
- Package edge_det_pkg:
  - mode constants MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11
  - default parameter values
- Sub-module edge_det_channel: synchroniser, filter counter, level, pe/ne/ev and flag for one channel.
  - Ports: i_clk, i_rst, i_sig, i_mode[1:0], i_filt_len, i_clr, plus the per-bit outputs.
- Top: generate loop over N_CH, plus the o_any reduction.

Test Plan:
- Reset, i_sig=0, L=0, mode=01 on ch0. Raise i_sig[0] before edge k → o_level[0], o_pe[0], o_ev[0] high at edge k+2; o_pe/o_ev low at k+3; o_flag[0]=1, o_any=1.
- L=3, ch1, mode=11. 3-cycle high glitch → no o_pe/o_level change. Hold high 4+ cycles → o_pe[1] at k+2+3=k+5. Drop → o_ne[1] and o_ev[1] 5 cycles after the fall.
- ch2 mode=10 (fall). Rise then fall → o_pe[2] pulses without o_ev/flag; o_ne[2] pulses with o_ev[2] and o_flag[2]=1.
- ch3 mode=00. Toggle i_sig → o_level/o_pe/o_ne follow; o_ev[3]=0, o_flag[3]=0 throughout.
- Flag priority. Assert i_clr[0] in the same cycle o_ev[0] pulses → o_flag[0] stays 1. Assert i_clr[0] alone next cycle → o_flag[0]=0, o_any=0 if no other flags.
- Reset mid-count. L=7, ch4 mismatch for 4 cycles, assert i_rst → all outputs 0 immediately. Deassert with i_sig[4]=1 → rising edge after SYNC_STAGES+8 cycles; no earlier pulse.
